cop_issue_bridge: RTL and testbench
===================================

# cop_issue_bridge

CPU-side bridge that owns the CPU/COP instruction interface: it accepts instructions from the CPU pipeline, presents them to the COP on the `cpu_insn_req`/`cop_insn_ack` handshake, and collects COP results via `cop_insn_rsp`/`cpu_insn_ack` into a writeback register for the CPU pipeline. It sits directly upstream of the COP and of the formal transaction-capture logic. It must meet that logic's interface rules:

- Request and operands held stable until acknowledged.
- At most one instruction in flight.
- Responses taken in order.

## Interface
- `DEPTH`, default 2: issue FIFO entries; power of two, at least 2.
- `TIMEOUT`, default 255: cycles in WAIT without a response before the `timeout` flag sets; at least 1.

- `g_clk` in 1: global clock. All state updates on the rising edge.
- `g_reset` in 1: asynchronous, active-high reset.
- `iss_valid` in 1: CPU pipeline offers an instruction.
- `iss_ready` out 1: bridge can accept an instruction.
- `iss_enc` in 32: encoded instruction.
- `iss_rs1` in 32: RS1 operand.
- `cpu_insn_req` out 1: instruction request to the COP.
- `cop_insn_ack` in 1: COP accepts the request.
- `cpu_insn_enc` out 32: encoding presented to the COP.
- `cpu_rs1` out 32: RS1 presented to the COP.
- `cop_insn_rsp` in 1: COP has finished an instruction.
- `cpu_insn_ack` out 1: bridge accepts the COP response.
- `cop_wen` in 1: COP GPR write enable.
- `cop_waddr` in 5: COP GPR write address.
- `cop_wdata` in 32: COP GPR write data.
- `cop_result` in 3: COP execution result code.
- `wb_valid` out 1: writeback register holds a result.
- `wb_ready` in 1: CPU pipeline consumes the writeback.
- `wb_wen` out 1: captured `cop_wen`.
- `wb_waddr` out 5: captured `cop_waddr`.
- `wb_wdata` out 32: captured `cop_wdata`.
- `wb_result` out 3: captured `cop_result`.
- `busy` out 1: FIFO non-empty, or state is WAIT, or `wb_valid` is high.
- `timeout` out 1: sticky; a response took `TIMEOUT` or more cycles.
- `proto_err` out 1: sticky; `cop_insn_rsp` was seen outside WAIT.

## Operation
- **Issue FIFO:** holds `{enc, rs1}`, `DEPTH` entries.
  - Push on `iss_valid && iss_ready`, where `iss_ready = !full`.
  - Pop on `cpu_insn_req && cop_insn_ack`.
  - When full, no push is possible. A simultaneous pop frees the slot from the next cycle.
  - Read and write pointers wrap modulo `DEPTH`. The count register is `$clog2(DEPTH)+1` bits.
- **FSM, two states:**
  - ISSUE (reset state): `cpu_insn_req = !empty`. `cpu_insn_enc`/`cpu_rs1` = FIFO head, otherwise zero when the FIFO is empty. On request handshake, pop and go to WAIT.
  - WAIT: `cpu_insn_req = 0`. `cpu_insn_ack = cop_insn_rsp && (!wb_valid || wb_ready)`. On `cop_insn_rsp && cpu_insn_ack`, go to ISSUE.
- **Stability:** the head changes only on pop, so once `cpu_insn_req` rises, it and the operands stay stable until `cop_insn_ack`.
- **Writeback register:** on the response handshake, load `cop_wen/waddr/wdata/result` and set `wb_valid`. Otherwise, `wb_valid && wb_ready` clears `wb_valid`. A same-cycle drain and load leaves `wb_valid` set with the new data.
- **Watchdog:** an 8..32-bit counter (sized to `TIMEOUT`) clears on entry to WAIT and increments each WAIT cycle without a response handshake. It saturates at `TIMEOUT`; reaching `TIMEOUT` sets `timeout`. The FSM does not abort and keeps waiting.
- **`proto_err`:** sets when `cop_insn_rsp` is seen in ISSUE. `cpu_insn_ack` stays 0 in that case and the response is dropped.
- **Reset**, including mid-transaction: asynchronously clears the FIFO contents, pointers, FSM (to ISSUE), writeback register and all flags. In-flight instructions are discarded.

## Timing
- Reset values: every output is 0 except `iss_ready`, which is 1.
- Push at cycle N gives `cpu_insn_req` high at N+1 if the FSM is in ISSUE.
- Request handshake at cycle K: WAIT from K+1. The earliest response handshake is K+1, giving ISSUE and the next `cpu_insn_req` at K+2. Peak throughput is one instruction per 2 cycles.
- Response handshake at cycle R gives `wb_valid` high at R+1.
- With `wb_valid` high and `wb_ready` low, `cpu_insn_ack` is held low and the response is stalled at the COP.
- `cpu_insn_req`, `cpu_insn_enc`, `cpu_rs1` and `wb_*` are registered or driven from FIFO storage. `cpu_insn_ack` is combinational from `cop_insn_rsp`, `wb_valid` and `wb_ready`.

## Test plan
- **Single instruction:** push enc=0x0000_1234, rs1=0xDEAD_BEEF at cycle 1. Require `cpu_insn_req` at cycle 2 with the same operands. Drive ack at 4 and rsp with waddr=5, wdata=0xCAFE_0001, result=0 at 6. Require `wb_valid` at 7 with those fields and `busy` low after `wb_ready`.
- **Request stall:** hold `cop_insn_ack` low for 10 cycles. Require `cpu_insn_req`, `cpu_insn_enc` and `cpu_rs1` constant throughout, and `iss_ready` low once 2 more instructions are pushed (DEPTH=2).
- **Writeback backpressure:** with `wb_valid` high and `wb_ready` low, assert `cop_insn_rsp`. Require `cpu_insn_ack` 0. Raise `wb_ready`; require `cpu_insn_ack` 1 in the same cycle and the new data in `wb_*` next cycle with `wb_valid` still 1.
- **Back-to-back:** 3 pushes with COP ack/rsp always high. Require requests at cycles 2, 4, 6 and in-order `wb_*` results.
- **Watchdog and protocol error:** TIMEOUT=4. Withhold the response for 6 cycles; require `timeout` to set after 4 WAIT cycles, then complete normally. Separately, pulse `cop_insn_rsp` in ISSUE; require `proto_err` set and `cpu_insn_ack` 0.
- **Reset mid-flight:** assert `g_reset` during WAIT with 1 FIFO entry queued. Require all outputs at reset values immediately, and no request after deassertion until a new push.

Source files
------------

// File: rtl/cop_issue_bridge_if.sv
// Handshake and data bundle between the CPU pipeline, the COP and the issue bridge.
// The master modport is the bridge's own view; slave is the surrounding environment.
interface cop_issue_bridge_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_enc;
  logic [31:0] iss_rs1;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [2:0]  wb_result;
  logic        busy;
  logic        timeout;
  logic        proto_err;

  modport master (
    input  iss_valid, iss_enc, iss_rs1, cop_insn_ack, cop_insn_rsp,
           cop_wen, cop_waddr, cop_wdata, cop_result, wb_ready,
    output iss_ready, cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
           wb_valid, wb_wen, wb_waddr, wb_wdata, wb_result, busy, timeout, proto_err
  );

  modport slave (
    output iss_valid, iss_enc, iss_rs1, cop_insn_ack, cop_insn_rsp,
           cop_wen, cop_waddr, cop_wdata, cop_result, wb_ready,
    input  iss_ready, cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
           wb_valid, wb_wen, wb_waddr, wb_wdata, wb_result, busy, timeout, proto_err
  );
endinterface

// File: rtl/cop_issue_bridge.sv
// CPU-side COP issue bridge: issue FIFO, one-in-flight request/response FSM,
// writeback register, response watchdog and protocol-error flag.
module cop_issue_bridge #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  cop_issue_bridge_if.master   bif
);

  localparam int AW      = $clog2(DEPTH);
  localparam int WD_RAW  = $clog2(TIMEOUT + 1);
  localparam int WDW     = (WD_RAW < 8) ? 8 : ((WD_RAW > 32) ? 32 : WD_RAW);
  localparam logic [WDW-1:0] TO_VAL = WDW'(TIMEOUT);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [0:0] S_ISSUE = 1'b0;
  localparam logic [0:0] S_WAIT  = 1'b1;

  logic [31:0]    r_enc_mem [DEPTH];
  logic [31:0]    r_rs1_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic [0:0]     r_state;
  logic [WDW-1:0] r_wd_cnt;
  logic           r_wb_valid;
  logic           r_wb_wen;
  logic [4:0]     r_wb_waddr;
  logic [31:0]    r_wb_wdata;
  logic [2:0]     r_wb_result;
  logic           r_timeout;
  logic           r_proto_err;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_req;
  logic w_rsp_hs;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_push   = bif.iss_valid && !w_full;
  assign w_req    = (r_state == S_ISSUE) && !w_empty;
  assign w_pop    = w_req && bif.cop_insn_ack;
  // Response is only taken in WAIT and only when the writeback slot is free or draining.
  assign w_rsp_hs = (r_state == S_WAIT) && bif.cop_insn_rsp && (!r_wb_valid || bif.wb_ready);

  assign bif.iss_ready    = !w_full;
  assign bif.cpu_insn_req = w_req;
  assign bif.cpu_insn_enc = w_empty ? '0 : r_enc_mem[r_rptr];
  assign bif.cpu_rs1      = w_empty ? '0 : r_rs1_mem[r_rptr];
  assign bif.cpu_insn_ack = w_rsp_hs;
  assign bif.wb_valid     = r_wb_valid;
  assign bif.wb_wen       = r_wb_wen;
  assign bif.wb_waddr     = r_wb_waddr;
  assign bif.wb_wdata     = r_wb_wdata;
  assign bif.wb_result    = r_wb_result;
  assign bif.busy         = !w_empty || (r_state == S_WAIT) || r_wb_valid;
  assign bif.timeout      = r_timeout;
  assign bif.proto_err    = r_proto_err;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_enc_mem[i] <= '0;
        r_rs1_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_enc_mem[r_wptr] <= bif.iss_enc;
        r_rs1_mem[r_wptr] <= bif.iss_rs1;
        r_wptr            <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state     <= S_ISSUE;
      r_wd_cnt    <= '0;
      r_timeout   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (bif.cop_insn_rsp) r_proto_err <= 1'b1;
          if (w_pop) begin
            r_state  <= S_WAIT;
            r_wd_cnt <= '0;
          end
        end
        default: begin
          if (w_rsp_hs) begin
            r_state <= S_ISSUE;
          end else begin
            // Saturating watchdog; the FSM keeps waiting after it fires.
            if (r_wd_cnt != TO_VAL) r_wd_cnt <= r_wd_cnt + 1'b1;
            if (r_wd_cnt >= TO_VAL - 1'b1) r_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_wb_valid  <= 1'b0;
      r_wb_wen    <= 1'b0;
      r_wb_waddr  <= '0;
      r_wb_wdata  <= '0;
      r_wb_result <= '0;
    end else if (w_rsp_hs) begin
      r_wb_valid  <= 1'b1;
      r_wb_wen    <= bif.cop_wen;
      r_wb_waddr  <= bif.cop_waddr;
      r_wb_wdata  <= bif.cop_wdata;
      r_wb_result <= bif.cop_result;
    end else if (r_wb_valid && bif.wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cop_issue_bridge.sv
// Directed bench for cop_issue_bridge (DEPTH=2, TIMEOUT=4): inputs change 1ns after
// the rising edge, outputs are checked on the falling edge.
module tb_cop_issue_bridge;
  logic g_clk;
  logic g_reset;
  int   n_tests;
  int   n_fail;

  cop_issue_bridge_if bif();

  cop_issue_bridge #(.DEPTH(2), .TIMEOUT(4)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bif     (bif)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge g_clk);
  endtask

  task automatic nxt();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iss_ready"}, 32'(bif.iss_ready), 32'd1);
    chk({tag, "_req"},       32'(bif.cpu_insn_req), 32'd0);
    chk({tag, "_enc"},       bif.cpu_insn_enc, 32'd0);
    chk({tag, "_rs1"},       bif.cpu_rs1, 32'd0);
    chk({tag, "_ack"},       32'(bif.cpu_insn_ack), 32'd0);
    chk({tag, "_wb_valid"},  32'(bif.wb_valid), 32'd0);
    chk({tag, "_wb_wen"},    32'(bif.wb_wen), 32'd0);
    chk({tag, "_wb_waddr"},  32'(bif.wb_waddr), 32'd0);
    chk({tag, "_wb_wdata"},  bif.wb_wdata, 32'd0);
    chk({tag, "_wb_result"}, 32'(bif.wb_result), 32'd0);
    chk({tag, "_busy"},      32'(bif.busy), 32'd0);
    chk({tag, "_timeout"},   32'(bif.timeout), 32'd0);
    chk({tag, "_proto_err"}, 32'(bif.proto_err), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    g_reset = 1'b1;
    bif.iss_valid = 1'b0; bif.iss_enc = '0; bif.iss_rs1 = '0;
    bif.cop_insn_ack = 1'b0; bif.cop_insn_rsp = 1'b0;
    bif.cop_wen = 1'b0; bif.cop_waddr = '0; bif.cop_wdata = '0; bif.cop_result = '0;
    bif.wb_ready = 1'b0;
    #12;
    chk_reset_outputs("rst");
    #4 g_reset = 1'b0;
    nxt();

    // Single instruction
    bif.iss_valid = 1'b1; bif.iss_enc = 32'h0000_1234; bif.iss_rs1 = 32'hDEAD_BEEF;
    mid(); chk("t1_c1_ready", 32'(bif.iss_ready), 32'd1); chk("t1_c1_req", 32'(bif.cpu_insn_req), 32'd0);
    nxt();
    bif.iss_valid = 1'b0;
    mid(); chk("t1_c2_req", 32'(bif.cpu_insn_req), 32'd1);
    chk("t1_c2_enc", bif.cpu_insn_enc, 32'h0000_1234); chk("t1_c2_rs1", bif.cpu_rs1, 32'hDEAD_BEEF);
    nxt();
    mid(); chk("t1_c3_req", 32'(bif.cpu_insn_req), 32'd1);
    nxt();
    bif.cop_insn_ack = 1'b1;
    mid(); chk("t1_c4_req", 32'(bif.cpu_insn_req), 32'd1);
    nxt();
    bif.cop_insn_ack = 1'b0;
    mid(); chk("t1_c5_req", 32'(bif.cpu_insn_req), 32'd0); chk("t1_c5_busy", 32'(bif.busy), 32'd1);
    chk("t1_c5_ack", 32'(bif.cpu_insn_ack), 32'd0);
    nxt();
    bif.cop_insn_rsp = 1'b1; bif.cop_wen = 1'b1; bif.cop_waddr = 5'd5;
    bif.cop_wdata = 32'hCAFE_0001; bif.cop_result = 3'd0;
    mid(); chk("t1_c6_ack", 32'(bif.cpu_insn_ack), 32'd1);
    nxt();
    bif.cop_insn_rsp = 1'b0; bif.wb_ready = 1'b1;
    mid(); chk("t1_c7_wb_valid", 32'(bif.wb_valid), 32'd1); chk("t1_c7_wb_wen", 32'(bif.wb_wen), 32'd1);
    chk("t1_c7_wb_waddr", 32'(bif.wb_waddr), 32'd5); chk("t1_c7_wb_wdata", bif.wb_wdata, 32'hCAFE_0001);
    chk("t1_c7_wb_result", 32'(bif.wb_result), 32'd0);
    nxt();
    bif.wb_ready = 1'b0;
    mid(); chk("t1_c8_wb_valid", 32'(bif.wb_valid), 32'd0); chk("t1_c8_busy", 32'(bif.busy), 32'd0);
    nxt();

    // Request stall, FIFO full, then writeback backpressure
    bif.iss_valid = 1'b1; bif.iss_enc = 32'h11; bif.iss_rs1 = 32'hA1;
    mid(); chk("t2_push1_ready", 32'(bif.iss_ready), 32'd1);
    nxt();
    bif.iss_enc = 32'h22; bif.iss_rs1 = 32'hA2;
    mid(); chk("t2_push2_req", 32'(bif.cpu_insn_req), 32'd1); chk("t2_push2_enc", bif.cpu_insn_enc, 32'h11);
    nxt();
    bif.iss_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("t2_stall_req", 32'(bif.cpu_insn_req), 32'd1);
      chk("t2_stall_enc", bif.cpu_insn_enc, 32'h11);
      chk("t2_stall_rs1", bif.cpu_rs1, 32'hA1);
      chk("t2_stall_ready", 32'(bif.iss_ready), 32'd0);
      nxt();
    end
    bif.cop_insn_ack = 1'b1;
    mid(); chk("t2_pop_req", 32'(bif.cpu_insn_req), 32'd1); chk("t2_pop_ready", 32'(bif.iss_ready), 32'd0);
    nxt();
    bif.cop_insn_ack = 1'b0; bif.cop_insn_rsp = 1'b1; bif.cop_wen = 1'b1;
    bif.cop_waddr = 5'd1; bif.cop_wdata = 32'hAAAA; bif.cop_result = 3'd3;
    mid(); chk("t2_rsp_ack", 32'(bif.cpu_insn_ack), 32'd1); chk("t2_rsp_ready", 32'(bif.iss_ready), 32'd1);
    chk("t2_rsp_req", 32'(bif.cpu_insn_req), 32'd0);
    nxt();
    bif.cop_insn_rsp = 1'b0; bif.cop_insn_ack = 1'b1;
    mid(); chk("t2_wb1_valid", 32'(bif.wb_valid), 32'd1); chk("t2_wb1_wdata", bif.wb_wdata, 32'hAAAA);
    chk("t2_wb1_result", 32'(bif.wb_result), 32'd3);
    chk("t2_x2_req", 32'(bif.cpu_insn_req), 32'd1); chk("t2_x2_enc", bif.cpu_insn_enc, 32'h22);
    chk("t2_x2_rs1", bif.cpu_rs1, 32'hA2);
    nxt();
    bif.cop_insn_ack = 1'b0; bif.cop_insn_rsp = 1'b1; bif.cop_waddr = 5'd2;
    bif.cop_wdata = 32'hBBBB; bif.cop_result = 3'd5; bif.wb_ready = 1'b0;
    mid(); chk("t3_bp_ack", 32'(bif.cpu_insn_ack), 32'd0); chk("t3_bp_wdata", bif.wb_wdata, 32'hAAAA);
    nxt();
    bif.wb_ready = 1'b1;
    mid(); chk("t3_release_ack", 32'(bif.cpu_insn_ack), 32'd1);
    nxt();
    bif.cop_insn_rsp = 1'b0; bif.wb_ready = 1'b0;
    mid(); chk("t3_wb2_valid", 32'(bif.wb_valid), 32'd1); chk("t3_wb2_wdata", bif.wb_wdata, 32'hBBBB);
    chk("t3_wb2_waddr", 32'(bif.wb_waddr), 32'd2); chk("t3_wb2_result", 32'(bif.wb_result), 32'd5);
    nxt();
    bif.wb_ready = 1'b1;
    mid(); chk("t3_drain_valid", 32'(bif.wb_valid), 32'd1);
    nxt();
    bif.wb_ready = 1'b0;
    mid(); chk("t3_idle_valid", 32'(bif.wb_valid), 32'd0); chk("t3_idle_busy", 32'(bif.busy), 32'd0);
    nxt();

    // Back-to-back with ack/rsp tied high
    bif.cop_insn_ack = 1'b1; bif.cop_insn_rsp = 1'b1; bif.wb_ready = 1'b1;
    bif.iss_valid = 1'b1; bif.iss_enc = 32'hA; bif.iss_rs1 = 32'h1A; bif.cop_wdata = 32'h0;
    mid(); chk("t4_c1_req", 32'(bif.cpu_insn_req), 32'd0);
    nxt();
    bif.iss_enc = 32'hB; bif.iss_rs1 = 32'h1B;
    mid(); chk("t4_c2_req", 32'(bif.cpu_insn_req), 32'd1); chk("t4_c2_enc", bif.cpu_insn_enc, 32'hA);
    nxt();
    bif.iss_enc = 32'hC; bif.iss_rs1 = 32'h1C; bif.cop_wdata = 32'hA0;
    mid(); chk("t4_c3_req", 32'(bif.cpu_insn_req), 32'd0); chk("t4_c3_ack", 32'(bif.cpu_insn_ack), 32'd1);
    nxt();
    bif.iss_valid = 1'b0;
    mid(); chk("t4_c4_req", 32'(bif.cpu_insn_req), 32'd1); chk("t4_c4_enc", bif.cpu_insn_enc, 32'hB);
    chk("t4_c4_wb_valid", 32'(bif.wb_valid), 32'd1); chk("t4_c4_wdata", bif.wb_wdata, 32'hA0);
    nxt();
    bif.cop_wdata = 32'hB0;
    mid(); chk("t4_c5_req", 32'(bif.cpu_insn_req), 32'd0);
    nxt();
    mid(); chk("t4_c6_req", 32'(bif.cpu_insn_req), 32'd1); chk("t4_c6_enc", bif.cpu_insn_enc, 32'hC);
    chk("t4_c6_wdata", bif.wb_wdata, 32'hB0);
    nxt();
    bif.cop_wdata = 32'hC0;
    mid(); chk("t4_c7_req", 32'(bif.cpu_insn_req), 32'd0);
    nxt();
    bif.cop_insn_ack = 1'b0; bif.cop_insn_rsp = 1'b0;
    mid(); chk("t4_c8_wb_valid", 32'(bif.wb_valid), 32'd1); chk("t4_c8_wdata", bif.wb_wdata, 32'hC0);
    nxt();
    bif.wb_ready = 1'b0;
    mid(); chk("t4_c9_wb_valid", 32'(bif.wb_valid), 32'd0); chk("t4_c9_busy", 32'(bif.busy), 32'd0);
    nxt();

    // Watchdog
    mid(); chk("t5_pre_timeout", 32'(bif.timeout), 32'd0);
    nxt();
    bif.iss_valid = 1'b1; bif.iss_enc = 32'h55; bif.iss_rs1 = 32'h66;
    nxt();
    bif.iss_valid = 1'b0; bif.cop_insn_ack = 1'b1;
    mid(); chk("t5_req", 32'(bif.cpu_insn_req), 32'd1);
    nxt();
    bif.cop_insn_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("t5_wait_timeout", 32'(bif.timeout), (i >= 4) ? 32'd1 : 32'd0);
      chk("t5_wait_busy", 32'(bif.busy), 32'd1);
      chk("t5_wait_req", 32'(bif.cpu_insn_req), 32'd0);
      nxt();
    end
    bif.cop_insn_rsp = 1'b1; bif.cop_wdata = 32'h5555;
    mid(); chk("t5_late_ack", 32'(bif.cpu_insn_ack), 32'd1);
    nxt();
    bif.cop_insn_rsp = 1'b0; bif.wb_ready = 1'b1;
    mid(); chk("t5_wb_valid", 32'(bif.wb_valid), 32'd1); chk("t5_wb_wdata", bif.wb_wdata, 32'h5555);
    chk("t5_sticky", 32'(bif.timeout), 32'd1);
    nxt();
    bif.wb_ready = 1'b0;

    // Reset mid-flight: P1 in WAIT, P2 queued
    bif.iss_valid = 1'b1; bif.iss_enc = 32'h71; bif.iss_rs1 = 32'h81;
    nxt();
    bif.iss_enc = 32'h72; bif.iss_rs1 = 32'h82; bif.cop_insn_ack = 1'b1;
    mid(); chk("t6_p1_req", 32'(bif.cpu_insn_req), 32'd1);
    nxt();
    bif.iss_valid = 1'b0; bif.cop_insn_ack = 1'b0;
    #2 g_reset = 1'b1;
    #1 chk_reset_outputs("t6_async");
    #1 g_reset = 1'b0;
    nxt();
    for (int i = 0; i < 4; i++) begin
      mid(); chk("t6_no_req", 32'(bif.cpu_insn_req), 32'd0); chk("t6_no_busy", 32'(bif.busy), 32'd0);
      nxt();
    end
    bif.iss_valid = 1'b1; bif.iss_enc = 32'h73; bif.iss_rs1 = 32'h83;
    nxt();
    bif.iss_valid = 1'b0;
    mid(); chk("t6_new_req", 32'(bif.cpu_insn_req), 32'd1); chk("t6_new_enc", bif.cpu_insn_enc, 32'h73);
    chk("t6_new_rs1", bif.cpu_rs1, 32'h83);
    bif.cop_insn_ack = 1'b1;
    nxt();
    bif.cop_insn_ack = 1'b0; bif.cop_insn_rsp = 1'b1;
    nxt();
    bif.cop_insn_rsp = 1'b0; bif.wb_ready = 1'b1;
    nxt();
    bif.wb_ready = 1'b0;
    mid(); chk("t6_done_busy", 32'(bif.busy), 32'd0); chk("t6_proto_clean", 32'(bif.proto_err), 32'd0);
    nxt();

    // Response in ISSUE is a protocol error and is dropped
    bif.cop_insn_rsp = 1'b1; bif.cop_wdata = 32'hDEAD;
    mid(); chk("t7_ack", 32'(bif.cpu_insn_ack), 32'd0);
    nxt();
    bif.cop_insn_rsp = 1'b0;
    mid(); chk("t7_proto_err", 32'(bif.proto_err), 32'd1); chk("t7_wb_valid", 32'(bif.wb_valid), 32'd0);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
